// File: rtl/count_bcd_n.sv
// Cascaded BCD up/down counter with parallel load and terminal count.
// Define COUNT_BCD_SAT_EN to saturate at the end values instead of wrapping.
module count_bcd_n #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   counter_value,
    output logic                  tc
);

    logic [4*DIGITS-1:0] count;
    logic [4*DIGITS-1:0] count_step;
    logic [4*DIGITS-1:0] load_clamped;
    logic                all9;
    logic                all0;
    logic                carry;
    logic [3:0]          d;

    always_comb begin
        all9 = 1'b1;
        all0 = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (count[4*k +: 4] != 4'd9) all9 = 1'b0;
            if (count[4*k +: 4] != 4'd0) all0 = 1'b0;
        end
    end

    assign tc = up ? all9 : all0;

    // Ripple the borrow/carry from digit 0 upward.
    always_comb begin
        count_step = count;
        carry      = 1'b1;
        d          = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            d = count[4*k +: 4];
            if (carry) begin
                if (up)
                    count_step[4*k +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
                else
                    count_step[4*k +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
            end
            carry = carry & (up ? (d == 4'd9) : (d == 4'd0));
        end
`ifdef COUNT_BCD_SAT_EN
        if (tc) count_step = count;
`else
`endif
    end

    always_comb begin
        load_clamped = load_value;
        for (int k = 0; k < DIGITS; k++) begin
            if (load_value[4*k +: 4] > 4'd9) load_clamped[4*k +: 4] = 4'd9;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_clamped;
        else if (en)
            count <= count_step;
    end

    assign counter_value = count;

endmodule
